// File: rtl/sysid_info_regs_if.sv
// Avalon-MM style CSR bus bundle for the system-ID / build-info slave.
interface sysid_info_regs_if;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address, read, write, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/sysid_info_regs.sv
// System-ID / build-info CSR slave: build constants, scratch register,
// free-running uptime counter with a coherent LO/HI snapshot read path.
module sysid_info_regs #(
   parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
   parameter logic [31:0] VERSION       = 32'h0001_0000,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
   parameter int          UPTIME_W      = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   sysid_info_regs_if.slave  bus
);

   localparam logic [2:0] ADDR_ID      = 3'd0;
   localparam logic [2:0] ADDR_TS      = 3'd1;
   localparam logic [2:0] ADDR_VER     = 3'd2;
   localparam logic [2:0] ADDR_SCRATCH = 3'd3;
   localparam logic [2:0] ADDR_UP_LO   = 3'd4;
   localparam logic [2:0] ADDR_UP_HI   = 3'd5;
   localparam logic [2:0] ADDR_CTRL    = 3'd6;

   logic [31:0]         scratch;
   logic [UPTIME_W-1:0] uptime;
   logic [31:0]         hi_snap;
   logic                uptime_en;
   logic [31:0]         readdata_q;
   logic                readdatavalid_q;

   logic                rd_accept;
   logic                scratch_wr;
   logic                ctrl_wr;
   logic                uptime_clr;
   logic [63:0]         uptime_ext;
   logic [31:0]         uptime_hi;
   logic [31:0]         rd_mux;

   // A read that collides with a write is dropped; the write wins.
   assign rd_accept  = bus.read && !bus.write;
   assign scratch_wr = bus.write && (bus.address == ADDR_SCRATCH);
   assign ctrl_wr    = bus.write && (bus.address == ADDR_CTRL);
   assign uptime_clr = ctrl_wr && bus.writedata[1];

   // Zero-extend the counter so the upper word is well defined for any width 33..64.
   assign uptime_ext = 64'(uptime);
   assign uptime_hi  = uptime_ext[63:32];

   // Read data select, fully decoded over all eight word addresses.
   always_comb begin
      rd_mux = 32'h0;
      case (bus.address)
         ADDR_ID:      rd_mux = ID_VALUE;
         ADDR_TS:      rd_mux = TIMESTAMP;
         ADDR_VER:     rd_mux = VERSION;
         ADDR_SCRATCH: rd_mux = scratch;
         ADDR_UP_LO:   rd_mux = uptime_ext[31:0];
         ADDR_UP_HI:   rd_mux = hi_snap;
         ADDR_CTRL:    rd_mux = {31'h0, uptime_en};
         default:      rd_mux = 32'h0;
      endcase
   end

   // Registered read response; readdata holds between responses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q      <= 32'h0;
         readdatavalid_q <= 1'b0;
      end else begin
         readdatavalid_q <= rd_accept;
         if (rd_accept) begin
            readdata_q <= rd_mux;
         end
      end
   end

   // Scratch register and uptime enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch   <= SCRATCH_RESET;
         uptime_en <= 1'b1;
      end else begin
         if (scratch_wr) begin
            scratch <= bus.writedata;
         end
         if (ctrl_wr) begin
            uptime_en <= bus.writedata[0];
         end
      end
   end

   // Uptime counter; a clear request beats the increment at the same edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         uptime <= '0;
      end else if (uptime_clr) begin
         uptime <= '0;
      end else if (uptime_en) begin
         uptime <= uptime + UPTIME_W'(1);
      end
   end

   // Upper-word snapshot, taken only when the low word is read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi_snap <= 32'h0;
      end else if (rd_accept && (bus.address == ADDR_UP_LO)) begin
         hi_snap <= uptime_hi;
      end
   end

   assign bus.readdata      = readdata_q;
   assign bus.readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Bench for sysid_info_regs: directed scenarios plus randomized traffic
// checked against a transaction-level register model.
module tb_sysid_info_regs;

   localparam logic [31:0] P_ID      = 32'h5192_62C9;
   localparam logic [31:0] P_TS      = 32'h6543_2100;
   localparam logic [31:0] P_VER     = 32'h0003_0007;
   localparam logic [31:0] P_SCR_RST = 32'h1234_5678;

   logic clock = 1'b0;
   logic reset_n;

   sysid_info_regs_if bus ();

   sysid_info_regs #(
      .ID_VALUE      (P_ID),
      .TIMESTAMP     (P_TS),
      .VERSION       (P_VER),
      .SCRATCH_RESET (P_SCR_RST),
      .UPTIME_W      (64)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // register model
   logic [31:0] m_scratch;
   logic [31:0] m_hisnap;
   logic [31:0] m_rdata;
   logic [63:0] m_cnt;
   logic        m_en;

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return P_ID;
         3'd1:    return P_TS;
         3'd2:    return P_VER;
         3'd3:    return m_scratch;
         3'd4:    return m_cnt[31:0];
         3'd5:    return m_hisnap;
         3'd6:    return {31'h0, m_en};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_scratch = P_SCR_RST;
      m_hisnap  = 32'h0;
      m_rdata   = 32'h0;
      m_cnt     = 64'h0;
      m_en      = 1'b1;
   endtask

   // One bus cycle: drive after a falling edge, accept at the rising edge,
   // check the response at the next falling edge.
   task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] a,
                            input logic [31:0] wd, input string tag);
      logic        clr;
      logic        exp_rdv;
      logic [63:0] nxt;
      bus.read      = rd;
      bus.write     = wr;
      bus.address   = a;
      bus.writedata = wd;
      @(posedge clock);
      exp_rdv = rd && !wr;
      if (exp_rdv) begin
         m_rdata = model_read(a);
         if (a == 3'd4) m_hisnap = m_cnt[63:32];
      end
      clr = wr && (a == 3'd6) && wd[1];
      nxt = clr ? 64'h0 : (m_en ? m_cnt + 64'd1 : m_cnt);
      if (wr && a == 3'd3) m_scratch = wd;
      if (wr && a == 3'd6) m_en = wd[0];
      m_cnt = nxt;
      @(negedge clock);
      checks++;
      if (bus.readdatavalid !== exp_rdv) begin
         failures++;
         $display("FAIL %s readdatavalid: got %0b expected %0b", tag, bus.readdatavalid, exp_rdv);
      end
      checks++;
      if (bus.readdata !== m_rdata) begin
         failures++;
         $display("FAIL %s readdata: got %08h expected %08h", tag, bus.readdata, m_rdata);
      end
      bus.read  = 1'b0;
      bus.write = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 3'd0, 32'h0, "idle");
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.address   = 3'd0;
      bus.writedata = 32'h0;
      model_reset();
      repeat (3) @(negedge clock);
      checks++;
      if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: got rdv=%0b data=%08h expected 0/0", bus.readdatavalid, bus.readdata);
      end
      reset_n = 1'b1;
      bus_cycle(1'b1, 1'b0, 3'd3, 32'h0, "reset_scratch");
      bus_cycle(1'b1, 1'b0, 3'd6, 32'h0, "reset_ctrl");
      bus_cycle(1'b1, 1'b0, 3'd5, 32'h0, "reset_hisnap");
   endtask

   task automatic test_ids();
      logic [31:0] exp_c [3];
      exp_c[0] = P_ID;
      exp_c[1] = P_TS;
      exp_c[2] = P_VER;
      for (int i = 0; i < 3; i++) begin
         bus_cycle(1'b1, 1'b0, 3'(i), 32'h0, "const");
         checks++;
         if (bus.readdata !== exp_c[i]) begin
            failures++;
            $display("FAIL const_addr%0d: got %08h expected %08h", i, bus.readdata, exp_c[i]);
         end
         idle(1);
      end
   endtask

   task automatic test_scratch();
      bus_cycle(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, "scr_wr");
      bus_cycle(1'b1, 1'b0, 3'd3, 32'h0, "scr_rd");
      checks++;
      if (bus.readdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL scratch_rw: got %08h expected deadbeef", bus.readdata);
      end
      bus_cycle(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, "ro_wr");
      bus_cycle(1'b1, 1'b0, 3'd0, 32'h0, "ro_rd");
      bus_cycle(1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, "rsv_wr");
      bus_cycle(1'b1, 1'b0, 3'd7, 32'h0, "rsv_rd");
   endtask

   task automatic test_snapshot();
      bus_cycle(1'b0, 1'b1, 3'd6, 32'h0, "snap_dis");
      force dut.uptime = 64'h0000_0000_FFFF_FFFE;
      m_cnt = 64'h0000_0000_FFFF_FFFE;
      idle(1);
      release dut.uptime;
      bus_cycle(1'b1, 1'b0, 3'd4, 32'h0, "snap_lo");
      checks++;
      if (bus.readdata !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL snap_lo: got %08h expected fffffffe", bus.readdata);
      end
      bus_cycle(1'b0, 1'b1, 3'd6, 32'h1, "snap_en");
      idle(5);
      bus_cycle(1'b1, 1'b0, 3'd5, 32'h0, "snap_hi");
      checks++;
      if (bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL snap_hi: got %08h expected 00000000", bus.readdata);
      end
      bus_cycle(1'b1, 1'b0, 3'd4, 32'h0, "snap_lo2");
      bus_cycle(1'b1, 1'b0, 3'd5, 32'h0, "snap_hi2");
      checks++;
      if (bus.readdata !== 32'h1) begin
         failures++;
         $display("FAIL snap_hi_carry: got %08h expected 00000001", bus.readdata);
      end
   endtask

   task automatic test_control();
      logic [31:0] first;
      bus_cycle(1'b0, 1'b1, 3'd6, 32'h0, "ctl_dis");
      bus_cycle(1'b1, 1'b0, 3'd4, 32'h0, "ctl_lo_a");
      first = bus.readdata;
      idle(9);
      bus_cycle(1'b1, 1'b0, 3'd4, 32'h0, "ctl_lo_b");
      checks++;
      if (bus.readdata !== first) begin
         failures++;
         $display("FAIL ctl_hold: got %08h expected %08h", bus.readdata, first);
      end
      bus_cycle(1'b0, 1'b1, 3'd6, 32'h3, "ctl_clr");
      bus_cycle(1'b1, 1'b0, 3'd4, 32'h0, "ctl_zero");
      checks++;
      if (bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL ctl_clear: got %08h expected 00000000", bus.readdata);
      end
      idle(3);
      bus_cycle(1'b1, 1'b0, 3'd4, 32'h0, "ctl_count");
      bus_cycle(1'b1, 1'b0, 3'd6, 32'h0, "ctl_rd");
      checks++;
      if (bus.readdata !== 32'h1) begin
         failures++;
         $display("FAIL ctl_readback: got %08h expected 00000001", bus.readdata);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         bus_cycle(1'b1, 1'b0, 3'(i), 32'h0, "b2b");
      end
      checks++;
      if (bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL b2b_addr7: got %08h expected 00000000", bus.readdata);
      end
   endtask

   task automatic test_rd_wr_collision();
      bus_cycle(1'b1, 1'b1, 3'd3, 32'hA5A5_0F0F, "coll");
      bus_cycle(1'b1, 1'b0, 3'd3, 32'h0, "coll_rd");
      checks++;
      if (bus.readdata !== 32'hA5A5_0F0F) begin
         failures++;
         $display("FAIL coll_scratch: got %08h expected a5a50f0f", bus.readdata);
      end
   endtask

   task automatic test_random();
      logic        rd;
      logic        wr;
      logic [2:0]  a;
      logic [31:0] wd;
      for (int i = 0; i < 300; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 3) == 0);
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         bus_cycle(rd, wr, a, wd, "rand");
      end
   endtask

   task automatic test_reset_mid_read();
      bus_cycle(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, "mr_wr");
      bus.read    = 1'b1;
      bus.address = 3'd0;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
         failures++;
         $display("FAIL mid_read_reset: got rdv=%0b data=%08h expected 0/0", bus.readdatavalid, bus.readdata);
      end
      bus.read = 1'b0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      bus_cycle(1'b1, 1'b0, 3'd3, 32'h0, "mr_scratch");
      checks++;
      if (bus.readdata !== P_SCR_RST) begin
         failures++;
         $display("FAIL mid_read_scratch: got %08h expected %08h", bus.readdata, P_SCR_RST);
      end
      bus_cycle(1'b1, 1'b0, 3'd6, 32'h0, "mr_ctrl");
   endtask

   initial begin
      test_reset();
      test_ids();
      test_scratch();
      test_snapshot();
      test_control();
      test_back_to_back();
      test_rd_wr_collision();
      test_random();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
